// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MEM-stage memory controller:
//   - MIPS load/store opcodes (6-bit primary opcode field)
//   - controller state encoding
//   - access-size classification and alignment helpers
// ---------------------------------------------------------------------------
package mips_pkg;

   // Loads
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   // Stores
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SB  = 6'b101000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      SZ_NONE = 2'd0,
      SZ_BYTE = 2'd1,
      SZ_HALF = 2'd2,
      SZ_WORD = 2'd3
   } size_e;

   // Access size of an opcode; SZ_NONE marks a non-memory instruction.
   function automatic size_e op_size(input logic [5:0] op);
      size_e sz;
      case (op)
         OP_LW, OP_SW:          sz = SZ_WORD;
         OP_LH, OP_LHU, OP_SH:  sz = SZ_HALF;
         OP_LB, OP_LBU, OP_SB:  sz = SZ_BYTE;
         default:               sz = SZ_NONE;
      endcase
      return sz;
   endfunction

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
             (op == OP_LB) || (op == OP_LBU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
   endfunction

   // lw is included so that a wide data bus returns a sign-extended word,
   // matching MIPS64 lw semantics; on a 32-bit bus it has no effect.
   function automatic logic is_signed_load(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
   endfunction

   // Natural alignment within the 32-bit word; bytes are always aligned.
   function automatic logic is_aligned(input size_e sz, input logic [1:0] a);
      logic ok;
      case (sz)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~a[0];
         SZ_WORD: ok = (a == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl_if
// Request/acknowledge data-memory bus between the MEM-stage controller
// (master) and the data memory (slave).
//   mem_req   : access request, held until mem_ack
//   mem_we    : 1 = write
//   mem_be    : little-endian byte enables, one per byte lane
//   mem_addr  : bus-word-aligned byte address
//   mem_wdata : lane-replicated store data
//   mem_ack   : memory completes the access this cycle
//   mem_rdata : read data, valid with mem_ack
// ---------------------------------------------------------------------------
interface mem_stage_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [DATA_W/8-1:0]   mem_be;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_ack;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align  (purely combinational)
// Lane steering for the MEM stage.
//   op_i      : opcode of the access
//   off_i     : byte offset of the access within the bus word
//   wdata_i   : store data (rt)
//   rdata_i   : raw read data from memory
//   be_o      : byte enables for the access
//   wdata_o   : store data replicated across lanes (sb/sh), else wdata_i
//   ld_data_o : addressed lane(s) of rdata_i, sign/zero extended
// ---------------------------------------------------------------------------
module mem_lane_align
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [5:0]                     op_i,
   input  logic [$clog2(DATA_W/8)-1:0]    off_i,
   input  logic [DATA_W-1:0]              wdata_i,
   input  logic [DATA_W-1:0]              rdata_i,
   output logic [DATA_W/8-1:0]            be_o,
   output logic [DATA_W-1:0]              wdata_o,
   output logic [DATA_W-1:0]              ld_data_o
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   size_e             sz;
   logic              sgn;
   logic [OFF_W-1:0]  half_base;
   logic [OFF_W-1:0]  word_base;
   logic [DATA_W-1:0] rep_b;
   logic [DATA_W-1:0] rep_h;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] mask;
   logic              msb;

   assign sz  = op_size(op_i);
   assign sgn = is_signed_load(op_i);

   // Lane bases: the half-word and 32-bit word containing the offset.
   assign half_base = off_i & ~OFF_W'(1);
   assign word_base = off_i & ~OFF_W'(3);

   always_comb begin
      be_o = '0;
      case (sz)
         SZ_BYTE: be_o = NB'(1)     << off_i;
         SZ_HALF: be_o = NB'(2'b11) << half_base;
         SZ_WORD: be_o = NB'(4'hF)  << word_base;
         default: be_o = '0;
      endcase
   end

   // Replicated store patterns: every lane carries the byte, every lane
   // pair carries the half-word, so the enables alone pick the target.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         assign rep_b[gi*8 +: 8] = wdata_i[7:0];
         if ((gi % 2) == 0) begin : g_lo
            assign rep_h[gi*8 +: 8] = wdata_i[7:0];
         end else begin : g_hi
            assign rep_h[gi*8 +: 8] = wdata_i[15:8];
         end
      end
   endgenerate

   always_comb begin
      case (sz)
         SZ_BYTE: wdata_o = rep_b;
         SZ_HALF: wdata_o = rep_h;
         default: wdata_o = wdata_i;
      endcase
   end

   // Move the addressed lane down to bit 0, then mask and extend. The
   // mask form keeps the extension generic for any DATA_W >= 32.
   assign shifted = rdata_i >> {off_i, 3'b000};

   always_comb begin
      mask = '0;
      msb  = 1'b0;
      case (sz)
         SZ_BYTE: begin
            mask = DATA_W'(8'hFF);
            msb  = shifted[7];
         end
         SZ_HALF: begin
            mask = DATA_W'(16'hFFFF);
            msb  = shifted[15];
         end
         SZ_WORD: begin
            mask = DATA_W'(32'hFFFF_FFFF);
            msb  = shifted[31];
         end
         default: begin
            mask = '0;
            msb  = 1'b0;
         end
      endcase
      ld_data_o = (shifted & mask) | ((sgn && msb) ? ~mask : '0);
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
// MEM-stage memory controller. Registers the EX/MEM operation, decodes all
// MIPS loads/stores, drives a req/ack data-memory bus with byte enables,
// stalls the pipeline while an access is outstanding, and returns
// sign/zero-extended load data.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   in_valid   : EX/MEM slot holds an instruction
//   op/addr/wdata : opcode, effective byte address, store data
//   stall      : hold upstream pipeline (combinational)
//   mem        : memory bus, master side
//   rd_data    : extended load result (registered)
//   rd_valid   : 1-cycle pulse when rd_data is updated
//   addr_exc   : 1-cycle pulse for a misaligned access
//   bus_err    : 1-cycle pulse when the access times out
// ---------------------------------------------------------------------------
module mem_stage_ctrl
   import mips_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [5:0]           op,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [DATA_W-1:0]    wdata,
   output logic                 stall,
   mem_stage_ctrl_if.master     mem,
   output logic [DATA_W-1:0]    rd_data,
   output logic                 rd_valid,
   output logic                 addr_exc,
   output logic                 bus_err
);

   localparam int NB     = DATA_W / 8;
   localparam int OFF_W  = $clog2(NB);
   localparam int CNT_W  = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
   localparam bit TO_EN  = (MAX_WAIT > 0);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [5:0]          op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                addr_exc_q, addr_exc_d;
   logic                bus_err_q, bus_err_d;

   logic                capture;
   size_e               in_sz;
   logic                in_mem;
   logic                in_go;
   logic                timeout;
   logic                in_req;

   logic [NB-1:0]       be;
   logic [DATA_W-1:0]   wdata_rep;
   logic [DATA_W-1:0]   ld_data;

   // Incoming instruction classification, evaluated on the capture edge.
   assign capture = in_valid && !stall;
   assign in_sz   = op_size(op);
   assign in_mem  = (in_sz != SZ_NONE);
   assign in_go   = in_mem && is_aligned(in_sz, addr[1:0]);

   assign in_req  = (state_q == ST_REQ);
   assign timeout = TO_EN && (cnt_q == CNT_W'(MAX_WAIT - 1));

   // Ack releases the stall in the same cycle so the next instruction is
   // taken on the ack edge (back-to-back accesses without a bubble).
   assign stall = in_req && !mem.mem_ack;

   mem_lane_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .op_i      (op_q),
      .off_i     (addr_q[OFF_W-1:0]),
      .wdata_i   (wdata_q),
      .rdata_i   (mem.mem_rdata),
      .be_o      (be),
      .wdata_o   (wdata_rep),
      .ld_data_o (ld_data)
   );

   // Bus outputs come from the captured registers and are forced to zero
   // outside REQ so an idle bus is quiet.
   assign mem.mem_req   = in_req;
   assign mem.mem_we    = in_req && is_store(op_q);
   assign mem.mem_be    = in_req ? be : '0;
   assign mem.mem_addr  = in_req ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign mem.mem_wdata = in_req ? wdata_rep : '0;

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign addr_exc = addr_exc_q;
   assign bus_err  = bus_err_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      addr_exc_d = 1'b0;
      bus_err_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (capture) begin
               if (in_go) begin
                  state_d = ST_REQ;
                  cnt_d   = '0;
               end else if (in_mem) begin
                  addr_exc_d = 1'b1;
               end
            end
         end

         ST_REQ: begin
            if (mem.mem_ack) begin
               if (is_load(op_q)) begin
                  rd_data_d  = ld_data;
                  rd_valid_d = 1'b1;
               end
               // The ack edge is also a capture edge.
               if (capture && in_go) begin
                  state_d = ST_REQ;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_IDLE;
                  if (capture && in_mem) begin
                     addr_exc_d = 1'b1;
                  end
               end
            end else if (timeout) begin
               state_d   = ST_IDLE;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         addr_exc_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         addr_exc_q <= addr_exc_d;
         bus_err_q  <= bus_err_d;
         if (capture) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Scoreboard bench: the driver pushes expected bus requests / address
// exceptions when it issues an instruction; a memory responder acks with a
// per-request latency; a negedge monitor pops and compares whenever the
// DUT presents a request, a load result, an exception or a bus error.
// ---------------------------------------------------------------------------
module tb_mem_stage_ctrl;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 32;
   localparam int MAX_WAIT = 15;
   localparam int NEVER    = 1000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [5:0]  op = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        stall;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        addr_exc;
   logic        bus_err;

   mem_stage_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus ();

   mem_stage_ctrl #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .op       (op),
      .addr     (addr),
      .wdata    (wdata),
      .stall    (stall),
      .mem      (mem_bus),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .addr_exc (addr_exc),
      .bus_err  (bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
   } req_t;

   req_t        req_q[$];
   logic [31:0] rd_q[$];
   int          exc_pending = 0;
   int          checks = 0;
   int          errors = 0;

   logic        late_ack = 1'b0;
   logic        force_rd_en = 1'b0;
   logic [31:0] force_rd = '0;

   // ---------------- reference model (own opcode literals) ----------------
   function automatic int size_of(input logic [5:0] o);
      case (o)
         6'b100011, 6'b101011:            return 4;
         6'b100001, 6'b100101, 6'b101001: return 2;
         6'b100000, 6'b100100, 6'b101000: return 1;
         default:                         return 0;
      endcase
   endfunction

   function automatic logic op_is_load(input logic [5:0] o);
      return (o[5:3] == 3'b100) && (size_of(o) != 0);
   endfunction

   function automatic logic op_is_store(input logic [5:0] o);
      return (o[5:3] == 3'b101) && (size_of(o) != 0);
   endfunction

   function automatic logic [3:0] exp_be(input logic [5:0] o, input logic [31:0] a);
      int sz = size_of(o);
      int v  = ((1 << sz) - 1) << (a % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [5:0] o, input logic [31:0] w);
      int sz = size_of(o);
      if (sz == 1) return {24'h0, w[7:0]} * 32'h0101_0101;
      if (sz == 2) return {16'h0, w[15:0]} * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] exp_load(input logic [5:0] o, input logic [31:0] a,
                                            input logic [31:0] rd);
      int          sz = size_of(o);
      logic [31:0] mask, v;
      logic        sgn;
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v    = (rd >> (8 * (a % 4))) & mask;
      sgn  = (o == 6'b100000) || (o == 6'b100001) || (o == 6'b100011);
      if (sgn && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   int   age = 0;
   int   cur_lat = 0;
   logic prev_req_r = 1'b0;
   logic prev_ack_r = 1'b0;

   initial begin
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            mem_bus.mem_ack = 1'b0;
            prev_req_r = 1'b0;
            prev_ack_r = 1'b0;
         end else begin
            if (mem_bus.mem_req) begin
               if (!prev_req_r || prev_ack_r) begin
                  age     = 0;
                  cur_lat = (req_q.size() > 0) ? req_q[0].lat : 0;
               end else begin
                  age++;
               end
               mem_bus.mem_ack   = (age == cur_lat);
               mem_bus.mem_rdata = force_rd_en ? force_rd : $urandom;
            end else begin
               mem_bus.mem_ack   = late_ack;
               mem_bus.mem_rdata = $urandom;
            end
            prev_req_r = mem_bus.mem_req;
            prev_ack_r = mem_bus.mem_ack;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic m_prev_req = 1'b0;
   logic m_prev_ack = 1'b0;
   int   req_cycles = 0;

   always @(negedge clk) begin
      req_t e;
      if (reset) begin
         m_prev_req = 1'b0;
         m_prev_ack = 1'b0;
         req_cycles = 0;
      end else begin
         chk("stall", 32'(stall), 32'(mem_bus.mem_req && !mem_bus.mem_ack));
         if (mem_bus.mem_req) begin
            if (!m_prev_req || m_prev_ack) begin
               req_cycles = 1;
               checks++;
               if (req_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_req: mem_req=1 addr=%h, no request pending",
                           mem_bus.mem_addr);
               end else begin
                  e = req_q[0];
                  chk("mem_we", 32'(mem_bus.mem_we), 32'(op_is_store(e.op)));
                  chk("mem_be", 32'(mem_bus.mem_be), 32'(exp_be(e.op, e.addr)));
                  chk("mem_addr", mem_bus.mem_addr, e.addr & ~32'h3);
                  if (op_is_store(e.op))
                     chk("mem_wdata", mem_bus.mem_wdata, exp_wdata(e.op, e.wdata));
               end
            end else begin
               req_cycles++;
            end
            if (mem_bus.mem_ack && req_q.size() > 0) begin
               e = req_q.pop_front();
               if (op_is_load(e.op))
                  rd_q.push_back(exp_load(e.op, e.addr, mem_bus.mem_rdata));
            end
         end else if (m_prev_req && !m_prev_ack && !bus_err) begin
            checks++;
            errors++;
            $display("FAIL req_dropped: mem_req fell without ack or bus_err");
         end

         if (bus_err) begin
            checks++;
            if (req_q.size() == 0 || req_q[0].lat != NEVER ||
                req_cycles != MAX_WAIT || mem_bus.mem_req) begin
               errors++;
               $display("FAIL bus_err: got req_cycles=%0d mem_req=%0d, expected %0d cycles, mem_req=0",
                        req_cycles, mem_bus.mem_req, MAX_WAIT);
            end
            if (req_q.size() > 0) void'(req_q.pop_front());
         end

         if (rd_valid) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rd_valid: rd_data=%h, no load pending", rd_data);
            end else begin
               chk("rd_data", rd_data, rd_q.pop_front());
            end
         end

         if (addr_exc) begin
            checks++;
            if (exc_pending == 0) begin
               errors++;
               $display("FAIL unexpected_addr_exc: got pulse, expected none");
            end else begin
               exc_pending--;
            end
         end

         m_prev_req = mem_bus.mem_req;
         m_prev_ack = mem_bus.mem_ack;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] w, input int lat);
      int   sz = size_of(o);
      int   n  = 0;
      req_t e;
      in_valid = 1'b1;
      op       = o;
      addr     = a;
      wdata    = w;
      if (sz > 0) begin
         if ((a % sz) == 0) begin
            e.op = o; e.addr = a; e.wdata = w; e.lat = lat;
            req_q.push_back(e);
         end else begin
            exc_pending++;
         end
      end
      $display("issue op=%b addr=%h wdata=%h lat=%0d", o, a, w, lat);
      do begin
         @(negedge clk);
         n++;
      end while (stall && n < 200);
      if (stall) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: stall still 1 after %0d cycles", n);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op       = '0;
   endtask

   task automatic drain();
      int n = 0;
      while ((req_q.size() != 0 || rd_q.size() != 0 || exc_pending != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_req_q", 32'(req_q.size()), 32'd0);
      chk("drain_rd_q", 32'(rd_q.size()), 32'd0);
      chk("drain_exc", 32'(exc_pending), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_mem_req"},   32'(mem_bus.mem_req), 32'd0);
      chk({tag, "_mem_we"},    32'(mem_bus.mem_we), 32'd0);
      chk({tag, "_mem_be"},    32'(mem_bus.mem_be), 32'd0);
      chk({tag, "_mem_addr"},  mem_bus.mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, mem_bus.mem_wdata, 32'd0);
      chk({tag, "_stall"},     32'(stall), 32'd0);
      chk({tag, "_rd_data"},   rd_data, 32'd0);
      chk({tag, "_rd_valid"},  32'(rd_valid), 32'd0);
      chk({tag, "_addr_exc"},  32'(addr_exc), 32'd0);
      chk({tag, "_bus_err"},   32'(bus_err), 32'd0);
   endtask

   logic [5:0] op_tab [12] = '{6'b100011, 6'b100001, 6'b100101, 6'b100000,
                               6'b100100, 6'b101011, 6'b101001, 6'b101000,
                               6'b000000, 6'b001000, 6'b100010, 6'b101110};

   // ---------------- main sequence ----------------
   initial begin
      int          sz;
      logic [5:0]  o;
      logic [31:0] a;
      int          lat;

      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      reset = 1'b0;
      @(posedge clk);
      #1;

      // sw, ack on second REQ cycle
      issue(6'b101011, 32'h10, 32'hDEAD_BEEF, 1);
      drain();
      // sb to lane 3, immediate ack
      issue(6'b101000, 32'h13, 32'h0000_00A5, 0);
      drain();
      // lb / lbu from lane 1 of 0x00008000
      force_rd_en = 1'b1;
      force_rd    = 32'h0000_8000;
      issue(6'b100000, 32'h21, 32'h0, 0);
      issue(6'b100100, 32'h21, 32'h0, 0);
      drain();
      force_rd_en = 1'b0;
      // misaligned lh, then a non-memory add
      issue(6'b100001, 32'h03, 32'h0, 0);
      issue(6'b000000, 32'h44, 32'h1234_5678, 0);
      drain();
      // lw that is never acked: timeout, then a late ack is ignored
      issue(6'b100011, 32'h80, 32'h0, NEVER);
      drain();
      late_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      late_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // two back-to-back lw, each acked on its first REQ cycle
      issue(6'b100011, 32'h100, 32'h0, 0);
      issue(6'b100011, 32'h104, 32'h0, 0);
      // third access: reset while waiting
      issue(6'b100011, 32'h108, 32'h0, NEVER);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_outputs_zero("midreq_reset");
      req_q.delete();
      rd_q.delete();
      exc_pending = 0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_reset_rd_valid", 32'(rd_valid), 32'd0);
      chk("post_reset_mem_req", 32'(mem_bus.mem_req), 32'd0);

      // randomized traffic
      for (int i = 0; i < 250; i++) begin
         o  = op_tab[$urandom_range(0, 11)];
         sz = size_of(o);
         a  = 32'($urandom_range(0, 255));
         if (sz > 0 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
         lat = ($urandom_range(0, 39) == 0) ? NEVER : int'($urandom_range(0, 3));
         issue(o, a, $urandom, lat);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
